// File: rtl/symbol_freq_sorter.sv
// Frame-based symbol/frequency sorter: load, odd-even transposition sort, stream out ascending.
// Optional macro SORTER_DROP_ZERO_FREQ_EN discards zero-frequency pairs at load time.
module symbol_freq_sorter #(
  parameter int unsigned DEPTH = 6,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] In_Freq_Data,
  input  logic [DW-1:0] In_Syml_Data,
  input  logic          In_enb,
  output logic          In_ready,
  output logic [DW-1:0] Sort_Freq_Data,
  output logic [DW-1:0] Sort_Syml_Data,
  output logic          Sort_enb,
  output logic          Sort_done,
  output logic          Sort_ovf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SORT, EMIT} state_t;

  state_t        state;
  logic [DW-1:0] freq [DEPTH];
  logic [DW-1:0] sym  [DEPTH];
  logic [DW-1:0] nfreq [DEPTH];
  logic [DW-1:0] nsym  [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] emit_idx;
  logic          keep_c;

`ifdef SORTER_DROP_ZERO_FREQ_EN
  assign keep_c = (In_Freq_Data != '0);
`else
  assign keep_c = 1'b1;
`endif

  // One odd-even transposition pass; pair parity follows the pass counter's LSB.
  always_comb begin
    nfreq = freq;
    nsym  = sym;
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if ((i[0] == pass_cnt[0]) && (CW'(i + 1) < count) && (freq[i] > freq[i+1])) begin
        nfreq[i]   = freq[i+1];
        nfreq[i+1] = freq[i];
        nsym[i]    = sym[i+1];
        nsym[i+1]  = sym[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      pass_cnt       <= '0;
      emit_idx       <= '0;
      In_ready       <= 1'b1;
      Sort_Freq_Data <= '0;
      Sort_Syml_Data <= '0;
      Sort_enb       <= 1'b0;
      Sort_done      <= 1'b0;
      Sort_ovf       <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        freq[i] <= '0;
        sym[i]  <= '0;
      end
    end else begin
      Sort_enb       <= 1'b0;
      Sort_done      <= 1'b0;
      Sort_Freq_Data <= '0;
      Sort_Syml_Data <= '0;
      case (state)
        IDLE: begin
          if (In_enb && keep_c) begin
            freq[0]  <= In_Freq_Data;
            sym[0]   <= In_Syml_Data;
            count    <= CW'(1);
            Sort_ovf <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (In_enb) begin
            if (keep_c) begin
              if (count < CW'(DEPTH)) begin
                freq[AW'(count)] <= In_Freq_Data;
                sym[AW'(count)]  <= In_Syml_Data;
                count            <= count + CW'(1);
              end else begin
                Sort_ovf <= 1'b1;
              end
            end
          end else begin
            pass_cnt <= '0;
            In_ready <= 1'b0;
            state    <= SORT;
          end
        end
        SORT: begin
          freq     <= nfreq;
          sym      <= nsym;
          pass_cnt <= pass_cnt + CW'(1);
          if (pass_cnt == CW'(DEPTH - 1)) begin
            emit_idx <= '0;
            state    <= EMIT;
          end
        end
        EMIT: begin
          // Stream stored entries, then a lone done pulse that also reopens the input.
          if (emit_idx < count) begin
            Sort_enb       <= 1'b1;
            Sort_Freq_Data <= freq[AW'(emit_idx)];
            Sort_Syml_Data <= sym[AW'(emit_idx)];
            emit_idx       <= emit_idx + CW'(1);
          end else begin
            Sort_done <= 1'b1;
            In_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_freq_sorter.sv
// Scoreboard bench for symbol_freq_sorter: stable-sort reference model, decoupled output monitor.
module tb_symbol_freq_sorter;
  localparam int unsigned DEPTH = 6;
  localparam int unsigned DW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] In_Freq_Data;
  logic [DW-1:0] In_Syml_Data;
  logic          In_enb;
  logic          In_ready;
  logic [DW-1:0] Sort_Freq_Data;
  logic [DW-1:0] Sort_Syml_Data;
  logic          Sort_enb;
  logic          Sort_done;
  logic          Sort_ovf;

  typedef struct {
    logic [7:0] sym;
    logic [7:0] freq;
  } pair_t;

  pair_t exp_q[$];
  int    checks  = 0;
  int    errors  = 0;
  logic  exp_ovf = 1'b0;

  symbol_freq_sorter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .In_Freq_Data   (In_Freq_Data),
    .In_Syml_Data   (In_Syml_Data),
    .In_enb         (In_enb),
    .In_ready       (In_ready),
    .Sort_Freq_Data (Sort_Freq_Data),
    .Sort_Syml_Data (Sort_Syml_Data),
    .Sort_enb       (Sort_enb),
    .Sort_done      (Sort_done),
    .Sort_ovf       (Sort_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pair_t mk(input int s, input int f);
    pair_t p;
    p.sym  = 8'(s);
    p.freq = 8'(f);
    return p;
  endfunction

  function automatic bit is_kept(input pair_t p);
`ifdef SORTER_DROP_ZERO_FREQ_EN
    return p.freq != 8'd0;
`else
    return 1'b1;
`endif
  endfunction

  // Reference: keep the first DEPTH accepted pairs, then emit them bucketed by frequency in arrival order.
  function automatic int model(input pair_t in_q[$], output pair_t out_q[$]);
    pair_t kept[$];
    int    n;
    foreach (in_q[j]) if (is_kept(in_q[j])) kept.push_back(in_q[j]);
    n = kept.size();
    while (kept.size() > DEPTH) void'(kept.pop_back());
    out_q = {};
    for (int f = 0; f < 256; f++)
      foreach (kept[j]) if (int'(kept[j].freq) == f) out_q.push_back(kept[j]);
    return n;
  endfunction

  // Monitor: every valid output pops one expectation; idle cycles must show zero data.
  always @(negedge clk) begin : monitor
    pair_t p;
    if (reset === 1'b0) begin
      chk("enb_done_exclusive", 32'(Sort_enb & Sort_done), 32'd0);
      if (Sort_enb) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pair", 32'd1, 32'd0);
        end else begin
          p = exp_q.pop_front();
          chk("sort_freq", 32'(Sort_Freq_Data), 32'(p.freq));
          chk("sort_sym", 32'(Sort_Syml_Data), 32'(p.sym));
        end
      end else begin
        chk("idle_data_zero", {16'd0, Sort_Freq_Data, Sort_Syml_Data}, 32'd0);
      end
    end
  end

  task automatic send_frame(input pair_t frm[$], input bit busy, input int reset_after);
    pair_t sorted[$];
    int    n, nk, first_e, done_e, seen, w;
    bit    first_kept;
    n          = model(frm, sorted);
    nk         = sorted.size();
    first_kept = 1'b0;
    chk("ovf_held", 32'(Sort_ovf), 32'(exp_ovf));
    w = 0;
    while (!In_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_before_frame", 32'(In_ready), 32'd1);
    foreach (sorted[j]) exp_q.push_back(sorted[j]);
    foreach (frm[j]) begin
      In_enb       = 1'b1;
      In_Freq_Data = frm[j].freq;
      In_Syml_Data = frm[j].sym;
      @(posedge clk); #1;
      chk("ready_load", 32'(In_ready), 32'd1);
      if (!first_kept && is_kept(frm[j])) begin
        first_kept = 1'b1;
        chk("ovf_clear_on_start", 32'(Sort_ovf), 32'd0);
      end
    end
    In_enb       = 1'b0;
    In_Freq_Data = 8'($urandom);
    In_Syml_Data = 8'($urandom);
    if (n > 0) exp_ovf = (n > int'(DEPTH));
    first_e = -1;
    done_e  = -1;
    seen    = 0;
    for (int e = 0; e <= int'(DEPTH) + nk + 4; e++) begin
      @(posedge clk); #1;
      if (nk > 0 && e <= int'(DEPTH) + nk) chk("ready_busy", 32'(In_ready), 32'd0);
      if (e == 0) chk("ovf_after_load", 32'(Sort_ovf), 32'(exp_ovf));
      if (Sort_enb) begin
        if (first_e < 0) first_e = e;
        seen++;
      end
      if (Sort_done) begin
        if (done_e < 0) done_e = e;
        else chk("single_done", 32'd1, 32'd0);
        chk("ready_on_done", 32'(In_ready), 32'd1);
      end
      if (reset_after > 0 && Sort_enb && seen == reset_after) begin
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_enb", 32'(Sort_enb), 32'd0);
        chk("rst_done", 32'(Sort_done), 32'd0);
        chk("rst_data", {16'd0, Sort_Freq_Data, Sort_Syml_Data}, 32'd0);
        chk("rst_ovf", 32'(Sort_ovf), 32'd0);
        chk("rst_ready", 32'(In_ready), 32'd1);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b0;
        In_enb = 1'b0;
        return;
      end
      In_enb = (busy && (e % 3 == 1) && e < int'(DEPTH) + nk) ? 1'b1 : 1'b0;
      In_Freq_Data = 8'($urandom);
      In_Syml_Data = 8'($urandom);
    end
    In_enb = 1'b0;
    if (nk > 0) begin
      chk("first_pair_edge", 32'(first_e), 32'(DEPTH + 1));
      chk("done_edge", 32'(done_e), 32'(int'(DEPTH) + 1 + nk));
      chk("burst_len", 32'(seen), 32'(nk));
    end else begin
      chk("no_output", 32'(seen), 32'd0);
      chk("no_done", 32'(done_e), 32'hffff_ffff);
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    pair_t f[$];
    reset        = 1'b1;
    In_enb       = 1'b0;
    In_Freq_Data = '0;
    In_Syml_Data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(In_ready), 32'd1);
    chk("reset_enb", 32'(Sort_enb), 32'd0);
    chk("reset_done", 32'(Sort_done), 32'd0);
    chk("reset_ovf", 32'(Sort_ovf), 32'd0);
    chk("reset_data", {16'd0, Sort_Freq_Data, Sort_Syml_Data}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic sort
    f = {};
    f.push_back(mk(46, 45)); f.push_back(mk(44, 13)); f.push_back(mk(43, 12));
    f.push_back(mk(45, 16)); f.push_back(mk(42, 9));  f.push_back(mk(41, 5));
    send_frame(f, 1'b0, 0);

    // Stability on equal frequencies
    f = {};
    f.push_back(mk(10, 7)); f.push_back(mk(11, 3)); f.push_back(mk(12, 7));
    send_frame(f, 1'b0, 0);

    // Overflow, then a frame that must clear the sticky flag
    f = {};
    for (int i = 0; i < 8; i++) f.push_back(mk(100 + i, 8 - i));
    send_frame(f, 1'b0, 0);
    f = {};
    f.push_back(mk(50, 2)); f.push_back(mk(51, 1));
    send_frame(f, 1'b0, 0);

    // In_enb pulses while busy must be ignored
    f = {};
    f.push_back(mk(46, 45)); f.push_back(mk(44, 13)); f.push_back(mk(43, 12));
    f.push_back(mk(45, 16)); f.push_back(mk(42, 9));  f.push_back(mk(41, 5));
    send_frame(f, 1'b1, 0);

    // Reset after the 2nd output pair, then a one-pair frame
    send_frame(f, 1'b0, 2);
    f = {};
    f.push_back(mk(20, 4));
    send_frame(f, 1'b0, 0);

    // Zero-frequency pairs
    f = {};
    f.push_back(mk(30, 0)); f.push_back(mk(31, 6));
    f.push_back(mk(32, 0)); f.push_back(mk(33, 2));
    send_frame(f, 1'b0, 0);

    // Randomized frames with many ties and zeros
    for (int t = 0; t < 30; t++) begin
      int n;
      n = int'($urandom_range(1, 8));
      f = {};
      for (int i = 0; i < n; i++) f.push_back(mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 7))));
      send_frame(f, 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
